// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_rdy, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_rdy, imem_data);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to imem, and feeds the IF/ID register
// with {pc, pc+2, instr, valid}, honouring stalls, redirects and HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_in,
  input  logic          redirect_in,
  input  logic [15:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic [15:0]   pc_out,
  output logic [15:0]   inc_pc_out,
  output logic [15:0]   instr_out,
  output logic          instr_valid,
  output logic          flush_out,
  output logic          halted
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN, S_HALT} state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] pend_pc_reg, pend_pc_next;
  logic [15:0] buf_reg, buf_next;
  logic [15:0] pc_out_reg, pc_out_next;
  logic [15:0] inc_pc_out_reg, inc_pc_out_next;
  logic [15:0] instr_out_reg, instr_out_next;
  logic        instr_valid_reg, instr_valid_next;
  logic        flush_reg;
  logic        do_deliver;
  logic [15:0] deliver_word;
  logic [15:0] pc_inc;

  assign pc_inc = pc_reg + 16'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_FETCH;
      pc_reg          <= RESET_PC;
      pend_pc_reg     <= 16'h0000;
      buf_reg         <= 16'h0000;
      pc_out_reg      <= 16'h0000;
      inc_pc_out_reg  <= 16'h0000;
      instr_out_reg   <= 16'h0000;
      instr_valid_reg <= 1'b0;
      flush_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_pc_reg     <= pend_pc_next;
      buf_reg         <= buf_next;
      pc_out_reg      <= pc_out_next;
      inc_pc_out_reg  <= inc_pc_out_next;
      instr_out_reg   <= instr_out_next;
      instr_valid_reg <= instr_valid_next;
      flush_reg       <= redirect_in;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pend_pc_next     = pend_pc_reg;
    buf_next         = buf_reg;
    pc_out_next      = pc_out_reg;
    inc_pc_out_next  = inc_pc_out_reg;
    instr_out_next   = instr_out_reg;
    instr_valid_next = instr_valid_reg;
    do_deliver       = 1'b0;
    deliver_word     = 16'h0000;

    case (state_reg)
      S_FETCH: begin
        if (redirect_in) begin
          instr_valid_next = 1'b0;
          if (imem.imem_rdy) begin
            pc_next = redirect_pc;
          end else begin
            pend_pc_next = redirect_pc;
            state_next   = S_DRAIN;
          end
        end else if (imem.imem_rdy) begin
          if (stall_in) begin
            buf_next   = imem.imem_data;
            state_next = S_HOLD;
          end else begin
            do_deliver   = 1'b1;
            deliver_word = imem.imem_data;
          end
        end else if (!stall_in) begin
          instr_valid_next = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect_in) begin
          pc_next          = redirect_pc;
          instr_valid_next = 1'b0;
          state_next       = S_FETCH;
        end else if (!stall_in) begin
          do_deliver   = 1'b1;
          deliver_word = buf_reg;
        end
      end
      S_DRAIN: begin
        // The outstanding request belongs to the wrong path; wait it out, then jump.
        instr_valid_next = 1'b0;
        if (redirect_in) pend_pc_next = redirect_pc;
        if (imem.imem_rdy) begin
          pc_next    = redirect_in ? redirect_pc : pend_pc_reg;
          state_next = S_FETCH;
        end
      end
      default: begin
        if (redirect_in) begin
          pc_next          = redirect_pc;
          instr_valid_next = 1'b0;
          state_next       = S_FETCH;
        end
      end
    endcase

    if (do_deliver) begin
      instr_out_next   = deliver_word;
      pc_out_next      = pc_reg;
      inc_pc_out_next  = pc_inc;
      instr_valid_next = 1'b1;
      pc_next          = pc_inc;
      state_next       = (deliver_word[15:12] == HALT_OP) ? S_HALT : S_FETCH;
    end
  end

  assign imem.imem_req  = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
  assign imem.imem_addr = pc_reg;
  assign pc_out         = pc_out_reg;
  assign inc_pc_out     = inc_pc_out_reg;
  assign instr_out      = instr_out_reg;
  assign instr_valid    = instr_valid_reg;
  assign flush_out      = flush_reg;
  assign halted         = (state_reg == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency imem model plus a transaction-level
// reference of the fetch stream, driven by directed and random stall/redirect/reset.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] pc_out, inc_pc_out, instr_out;
  logic        instr_valid, flush_out, halted;

  int vectors = 0;
  int miscompares = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .redirect_in(redirect_in),
    .redirect_pc(redirect_pc), .imem(bus), .pc_out(pc_out), .inc_pc_out(inc_pc_out),
    .instr_out(instr_out), .instr_valid(instr_valid), .flush_out(flush_out), .halted(halted)
  );

  always #5 clk = ~clk;

  // Program image: a HLT lives at 0006, everything else is 1000+addr.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0006) ? 16'hF000 : 16'h1000 + a;
  endfunction

  // imem model: each request answers after lat cycles (0 = same cycle).
  int       lat_min = 0;
  int       lat_max = 0;
  logic [1:0] wait_cnt, lat;

  always_comb begin
    bus.imem_rdy  = bus.imem_req && (wait_cnt >= lat);
    bus.imem_data = bus.imem_rdy ? mem_word(bus.imem_addr) : 16'hDEAD;
  end

  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_rdy) begin
      wait_cnt <= 2'd0;
      lat      <= 2'($urandom_range(lat_max, lat_min));
    end else begin
      wait_cnt <= wait_cnt + 2'd1;
    end
  end

  // Reference: where fetch is, whether a fetched word is parked, whether a
  // wrong-path response is still owed, and whether HLT has been seen.
  logic [15:0] m_pc, m_target, m_word;
  logic        m_parked, m_wrong_path, m_stopped;
  logic [15:0] m_pc_out, m_inc, m_instr;
  logic        m_valid, m_flush;

  task automatic model_reset();
    m_pc = 16'h0000; m_target = 16'h0000; m_word = 16'h0000;
    m_parked = 1'b0; m_wrong_path = 1'b0; m_stopped = 1'b0;
    m_pc_out = 16'h0000; m_inc = 16'h0000; m_instr = 16'h0000;
    m_valid = 1'b0; m_flush = 1'b0;
  endtask

  task automatic model_deliver(input logic [15:0] w);
    m_instr = w; m_pc_out = m_pc; m_inc = m_pc + 16'd2; m_valid = 1'b1;
    m_pc = m_pc + 16'd2;
    if (w[15:12] == 4'hF) m_stopped = 1'b1;
  endtask

  task automatic model_step(input logic rdy);
    if (rst) begin
      model_reset();
    end else begin
      m_flush = redirect_in;
      if (m_stopped) begin
        if (redirect_in) begin
          m_pc = redirect_pc; m_valid = 1'b0; m_stopped = 1'b0;
        end
      end else if (m_parked) begin
        if (redirect_in) begin
          m_parked = 1'b0; m_pc = redirect_pc; m_valid = 1'b0;
        end else if (!stall_in) begin
          m_parked = 1'b0;
          model_deliver(m_word);
        end
      end else if (m_wrong_path) begin
        m_valid = 1'b0;
        if (redirect_in) m_target = redirect_pc;
        if (rdy) begin
          m_wrong_path = 1'b0; m_pc = m_target;
        end
      end else if (redirect_in) begin
        m_valid = 1'b0;
        if (rdy) m_pc = redirect_pc;
        else begin
          m_wrong_path = 1'b1; m_target = redirect_pc;
        end
      end else if (rdy) begin
        if (stall_in) begin
          m_parked = 1'b1; m_word = mem_word(m_pc);
        end else begin
          model_deliver(mem_word(m_pc));
        end
      end else if (!stall_in) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic st, input logic rd, input logic [15:0] tgt);
    logic exp_req;
    @(negedge clk);
    rst = r; stall_in = st; redirect_in = rd; redirect_pc = tgt;
    #1;
    exp_req = !m_stopped && !m_parked;
    check("imem_req", {15'b0, bus.imem_req}, {15'b0, exp_req});
    if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
    model_step(bus.imem_rdy);
    @(posedge clk);
    #1;
    check("pc_out", pc_out, m_pc_out);
    check("inc_pc_out", inc_pc_out, m_inc);
    check("instr_out", instr_out, m_instr);
    check("instr_valid", {15'b0, instr_valid}, {15'b0, m_valid});
    check("flush_out", {15'b0, flush_out}, {15'b0, m_flush});
    check("halted", {15'b0, halted}, {15'b0, m_stopped});
    $display("cyc rst=%0b st=%0b rd=%0b tgt=%h -> pc_out=%h instr=%h v=%0b fl=%0b h=%0b",
             r, st, rd, tgt, pc_out, instr_out, instr_valid, flush_out, halted);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);

    // Zero-wait streaming from reset until the HLT at 0006, then resume at 0010.
    lat_min = 0; lat_max = 0;
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 16'h0010);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Three-cycle stall whose first cycle catches a zero-wait response.
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Two-cycle memory latency, then a redirect while a request is still owed.
    lat_min = 2; lat_max = 2;
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 16'h0040);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset while draining a wrong-path request.
    cycle(1'b0, 1'b0, 1'b1, 16'h0020);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // PC wrap from FFFE to 0000.
    lat_min = 0; lat_max = 0;
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFC);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Random mix of latency, stalls, redirects and occasional reset.
    lat_min = 0; lat_max = 2;
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] tgt;
      logic [7:0]  r8;
      r8  = 8'($urandom);
      tgt = ($urandom_range(7, 0) == 0) ? 16'hFFFC : {8'h00, r8[7:1], 1'b0};
      cycle($urandom_range(99, 0) == 0, $urandom_range(3, 0) == 0,
            $urandom_range(9, 0) == 0, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
